tri_fill_sequencer: RTL and testbench
=====================================

TRI_FILL_SEQUENCER -- requirements
Module: tri_fill_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of groups; legal range 2..16.
REQ-002 The block SHALL have parameter W = N*(N+1)/2, derived and not overridden, giving the packed output width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a fill sequence.
REQ-006 abort  input  1  request to stop an in-progress sequence.
REQ-007 a  input  1  fill source for even-numbered groups.
REQ-008 b  input  1  fill source for odd-numbered groups.
REQ-009 o  output  W  packed triangular register; group k SHALL occupy bits [k*(k+1)/2 + k : k*(k+1)/2], i.e. k+1 bits.
REQ-010 filled  output  N  bit k high means group k has been written since the last clear.
REQ-011 grp_idx  output  $clog2(N)  index of the group being written in LOAD; 0 otherwise.
REQ-012 busy  output  1  high while in LOAD.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-015 IDLE -> LOAD: on an edge with start=1 and abort=0, set o=0, filled=0, grp_idx=0.
- This edge SHALL NOT write any group.
REQ-016 In LOAD, each edge SHALL write group grp_idx, then increment grp_idx.
- Even group index: every bit = a sampled at that edge.
- Odd group index: every bit = b sampled at that edge.
- filled[grp_idx] SHALL be set in the same edge.
REQ-017 LOAD -> DONE: on the edge that writes group N-1; grp_idx SHALL return to 0.
REQ-018 DONE -> IDLE: unconditionally on the next edge; done=1 only while in DONE.
REQ-019 Latency: start accepted at edge E0 -> groups 0..N-1 written at E1..EN -> done high between EN and EN+1 -> busy high between E0 and EN.
REQ-020 start SHALL be ignored while in LOAD or DONE; no restart and no clear.
REQ-021 abort=1 in LOAD SHALL take priority over that edge's group write.
- Next state: IDLE.
- o and filled: hold their current values.
- done: not asserted.
REQ-022 abort SHALL be ignored in IDLE and DONE.
- In IDLE, abort=1 together with start=1 SHALL NOT start a sequence.
REQ-023 Bits of o outside the group being written SHALL hold their value on every edge.
REQ-024 o, filled and done SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-025 reset=1 at an edge SHALL force the following values, from any state, including mid-LOAD:
- state = IDLE
- o = 0, filled = 0, grp_idx = 0
- busy = 0, done = 0
REQ-026 reset SHALL take priority over start, abort and any group write.

Verification (N=4, W=10)
REQ-027 a=1, b=0 held, start pulsed at E0 -> o=10'h039 and filled=4'hF after E4; done=1 for exactly one cycle after E4; busy=1 for exactly 4 cycles.
REQ-028 a=0, b=1 held, start at E0 -> o=10'h3C6 after E4; grp_idx reads 0,1,2,3 across the LOAD cycles.
REQ-029 a=b=1, start at E0, abort=1 at E3 -> o=10'h007, filled=4'b0011, state IDLE after E3; done never asserted.
REQ-030 Start at E0, start re-pulsed at E2 -> ignored; sequence completes at E4 unchanged; o is not re-cleared.
REQ-031 reset=1 at E2 mid-LOAD -> after E2: o=0, filled=0, busy=0, done=0, grp_idx=0; a fresh start then completes normally.
REQ-032 a toggled every cycle starting a=1 at E1, b=0 -> each group reflects a or b sampled at its own write edge; the expected value of o is computed by the bench model.

Source files
------------

// File: rtl/tri_fill_sequencer.sv
// Triangular fill sequencer: after a start request, writes groups 0..N-1 of a packed
// triangular register (group k is k+1 bits wide) one per cycle from a (even) or b (odd).
module tri_fill_sequencer #(
  parameter  int N  = 4,
  localparam int W  = N * (N + 1) / 2,
  localparam int GW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          a,
  input  logic          b,
  output logic [W-1:0]  o,
  output logic [N-1:0]  filled,
  output logic [GW-1:0] grp_idx,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [GW-1:0] LAST_GRP = GW'(N - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  o_d;
  logic [N-1:0]  filled_d;
  logic [GW-1:0] grp_d;
  logic          done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      o       <= '0;
      filled  <= '0;
      grp_idx <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      o       <= o_d;
      filled  <= filled_d;
      grp_idx <= grp_d;
      done    <= done_d;
    end
  end

  // Everything holds by default; only the group selected by grp_idx is written in LOAD.
  always_comb begin
    state_d  = state_q;
    o_d      = o;
    filled_d = filled;
    grp_d    = grp_idx;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = LOAD;
          o_d      = '0;
          filled_d = '0;
          grp_d    = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          // Abort wins over this edge's write; partial contents stay visible.
          state_d = IDLE;
          grp_d   = '0;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (grp_idx == GW'(k)) begin
              for (int j = 0; j <= k; j++) begin
                o_d[k * (k + 1) / 2 + j] = (k % 2 == 0) ? a : b;
              end
              filled_d[k] = 1'b1;
            end
          end
          if (grp_idx == LAST_GRP) begin
            state_d = DONE;
            grp_d   = '0;
            done_d  = 1'b1;
          end else begin
            grp_d = grp_idx + GW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == LOAD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tri_fill_sequencer.sv
// Directed bench for tri_fill_sequencer (N=4, W=10): fill patterns, abort, restart
// attempts, mid-sequence reset and per-edge sampled sources.
module tb_tri_fill_sequencer;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int GW = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          a;
  logic          b;
  logic [W-1:0]  o;
  logic [N-1:0]  filled;
  logic [GW-1:0] grp_idx;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  tri_fill_sequencer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .o         (o),
    .filled    (filled),
    .grp_idx   (grp_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // expected packing: group g fills all its bits with v[g]
  function automatic logic [W-1:0] pack(input logic [N-1:0] v);
    pack = {{4{v[3]}}, {3{v[2]}}, {2{v[1]}}, v[0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; a = 1'b0; b = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] v;
  int           busy_cnt;
  int           done_cnt;

  initial begin
    do_reset();
    check("rst_o", 32'(o), 32'h0);
    check("rst_filled", 32'(filled), 32'h0);
    check("rst_grp", 32'(grp_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // start together with abort in IDLE must not start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", 32'(busy), 32'h0);
    check("start_abort_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // a=1, b=0: count busy and done cycles
    a = 1'b1; b = 1'b0; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    check("e0_o_cleared", 32'(o), 32'h0);
    check("e0_filled", 32'(filled), 32'h0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 4) begin
        check("a1_o", 32'(o), 32'h039);
        check("a1_filled", 32'(filled), 32'hF);
        check("a1_done_e4", 32'(done), 32'h1);
        check("a1_state_e4", 32'(dbg_state), 32'(ST_DONE));
      end
      tick();
    end
    check("a1_busy_cycles", 32'(busy_cnt), 32'd4);
    check("a1_done_cycles", 32'(done_cnt), 32'd1);
    check("a1_o_hold_idle", 32'(o), 32'h039);

    // a=0, b=1: grp_idx walks 0..3
    a = 1'b0; b = 1'b1; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    check("b1_o_cleared", 32'(o), 32'h0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("b1_grp_%0d", i), 32'(grp_idx), 32'(i));
      tick();
    end
    check("b1_o", 32'(o), 32'h3C6);
    check("b1_grp_done", 32'(grp_idx), 32'h0);
    check("b1_done", 32'(done), 32'h1);
    tick();
    check("b1_done_clr", 32'(done), 32'h0);

    // a=b=1, abort at E3
    a = 1'b1; b = 1'b1; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    tick();  // E1
    tick();  // E2
    abort = 1'b1;
    tick();  // E3
    abort = 1'b0;
    check("ab_o", 32'(o), 32'h007);
    check("ab_filled", 32'(filled), 32'h3);
    check("ab_state", 32'(dbg_state), 32'(ST_IDLE));
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_grp", 32'(grp_idx), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("ab_no_done", 32'(done_cnt), 32'd0);
    check("ab_o_hold", 32'(o), 32'h007);

    // start re-pulsed at E2 is ignored, no re-clear
    a = 1'b1; b = 1'b0; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    tick();  // E1
    start = 1'b1;
    tick();  // E2
    start = 1'b0;
    check("rs_o_e2", 32'(o), 32'h001);
    check("rs_filled_e2", 32'(filled), 32'h3);
    check("rs_grp_e2", 32'(grp_idx), 32'h2);
    tick();  // E3
    tick();  // E4
    check("rs_o", 32'(o), 32'h039);
    check("rs_done", 32'(done), 32'h1);
    abort = 1'b1;  // ignored in DONE
    tick();
    abort = 1'b0;
    check("rs_state_after_done", 32'(dbg_state), 32'(ST_IDLE));
    check("rs_o_after_done", 32'(o), 32'h039);

    // reset mid-LOAD at E2, then fresh run
    a = 1'b1; b = 1'b1; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    tick();  // E1
    reset = 1'b1;
    tick();  // E2
    reset = 1'b0;
    check("mr_o", 32'(o), 32'h0);
    check("mr_filled", 32'(filled), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_done", 32'(done), 32'h0);
    check("mr_grp", 32'(grp_idx), 32'h0);
    check("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) tick();
    check("mr_fresh_o", 32'(o), 32'h3FF);
    check("mr_fresh_filled", 32'(filled), 32'hF);
    check("mr_fresh_done", 32'(done), 32'h1);
    tick();

    // a toggling from a=1 at E1, b=0: each group takes its own edge's sample
    b = 1'b0; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    a = 1'b1;
    v = '0;
    for (int g = 0; g < N; g++) begin
      v[g] = (g % 2 == 0) ? a : b;
      tick();
      a = ~a;
    end
    check("tg_a_o", 32'(o), 32'(pack(v)));
    tick();

    // a toggling from a=0, b=1 held
    b = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    a = 1'b0;
    v = '0;
    for (int g = 0; g < N; g++) begin
      v[g] = (g % 2 == 0) ? a : b;
      tick();
      a = ~a;
    end
    check("tg_b_o", 32'(o), 32'(pack(v)));
    check("tg_b_done", 32'(done), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
